dnn_argmax_scorer: RTL and testbench

Downstream classification stage for the fp16 ReLU inference engine. On each rising edge of the engine's `done`, it captures the ten output scores and the expected label. It then runs a sequential argmax, one class per cycle, and emits the 1-based winning class index and its confidence. It compares the winner against the label and keeps running hit and total counters, which moves the accuracy bookkeeping out of the bench and into RTL.

---
 rtl/dnn_argmax_scorer.sv | 141 ++++++++++++++
 tb/tb_dnn_argmax_scorer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_argmax_scorer.sv
// Classification back end: on a rising edge of the engine's done, snapshot the scores
// and label, scan them one class per cycle for a strictly positive argmax, and track accuracy.
module dnn_argmax_scorer #(
   parameter int N_CLASSES  = 10,
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_clear,
   input  logic                                 i_done,
   input  logic [N_CLASSES-1:0][DATA_WIDTH-1:0] i_scores,
   input  logic [IDX_WIDTH-1:0]                 i_exp_y,
   output logic                                 o_busy,
   output logic                                 o_valid,
   output logic [IDX_WIDTH-1:0]                 o_class_idx,
   output logic signed [DATA_WIDTH-1:0]         o_confidence,
   output logic                                 o_hit,
   output logic [CNT_WIDTH-1:0]                 o_hit_cnt,
   output logic [CNT_WIDTH-1:0]                 o_total_cnt
);

   // o_busy is the FSM state itself (high exactly in SCAN).
   typedef enum logic {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   state_t                                r_state;
   state_t                                w_state_next;
   logic                                  r_done_q;
   logic [N_CLASSES-1:0][DATA_WIDTH-1:0]  r_buf;
   logic [IDX_WIDTH-1:0]                  r_exp_y;
   logic [IDX_WIDTH-1:0]                  r_ptr;
   logic [IDX_WIDTH-1:0]                  r_best_idx;
   logic signed [DATA_WIDTH-1:0]          r_best;
   logic                                  r_valid;
   logic [IDX_WIDTH-1:0]                  r_class_idx;
   logic signed [DATA_WIDTH-1:0]          r_confidence;
   logic                                  r_hit;
   logic [CNT_WIDTH-1:0]                  r_hit_cnt;
   logic [CNT_WIDTH-1:0]                  r_total_cnt;

   logic                                  w_start;
   logic                                  w_last;
   logic                                  w_take;
   logic signed [DATA_WIDTH-1:0]          w_cand;
   logic signed [DATA_WIDTH-1:0]          w_best_nxt;
   logic [IDX_WIDTH-1:0]                  w_idx_nxt;
   logic                                  w_hit;

   assign w_start    = i_done & ~r_done_q;
   assign w_last     = (r_ptr == IDX_WIDTH'(N_CLASSES - 1));
   assign w_cand     = r_buf[r_ptr];
   // Strict compare against a max seeded with 0: ties keep the lower class, non-positive never wins.
   assign w_take     = (w_cand > r_best);
   assign w_best_nxt = w_take ? w_cand : r_best;
   assign w_idx_nxt  = w_take ? (r_ptr + IDX_WIDTH'(1)) : r_best_idx;
   assign w_hit      = (w_idx_nxt == r_exp_y);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_start && !i_clear) w_state_next = S_SCAN;
         S_SCAN: if (i_clear || w_last)   w_state_next = S_IDLE;
      endcase
   end

   // Output protocol: o_valid is a one-cycle pulse with no back-pressure; result
   // fields change only on that edge and hold until the next pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_done_q     <= 1'b0;
         r_buf        <= '0;
         r_exp_y      <= '0;
         r_ptr        <= '0;
         r_best_idx   <= '0;
         r_best       <= '0;
         r_valid      <= 1'b0;
         r_class_idx  <= '0;
         r_confidence <= '0;
         r_hit        <= 1'b0;
         r_hit_cnt    <= '0;
         r_total_cnt  <= '0;
      end else begin
         r_done_q <= i_done;
         r_valid  <= 1'b0;
         if (i_clear) begin
            r_hit_cnt   <= '0;
            r_total_cnt <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_start) begin
                     r_buf      <= i_scores;
                     r_exp_y    <= i_exp_y;
                     r_best     <= '0;
                     r_best_idx <= '0;
                     r_ptr      <= '0;
                  end
               end
               S_SCAN: begin
                  r_best     <= w_best_nxt;
                  r_best_idx <= w_idx_nxt;
                  r_ptr      <= r_ptr + IDX_WIDTH'(1);
                  if (w_last) begin
                     r_valid      <= 1'b1;
                     r_class_idx  <= w_idx_nxt;
                     r_confidence <= w_best_nxt;
                     r_hit        <= w_hit;
                     if (r_total_cnt != {CNT_WIDTH{1'b1}}) begin
                        r_total_cnt <= r_total_cnt + CNT_WIDTH'(1);
                     end
                     if (w_hit && (r_hit_cnt != {CNT_WIDTH{1'b1}})) begin
                        r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
                     end
                  end
               end
            endcase
         end
      end
   end

   assign o_busy       = (r_state == S_SCAN);
   assign o_valid      = r_valid;
   assign o_class_idx  = r_class_idx;
   assign o_confidence = r_confidence;
   assign o_hit        = r_hit;
   assign o_hit_cnt    = r_hit_cnt;
   assign o_total_cnt  = r_total_cnt;

endmodule

// File: tb/tb_dnn_argmax_scorer.sv
// Bench for dnn_argmax_scorer: directed score vectors drive a default instance and a
// CNT_WIDTH=2 instance; a monitor pops expected results whenever valid pulses.
module tb_dnn_argmax_scorer;

   localparam int EW = 4 + 16 + 1 + 16 + 16 + 2 + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              clear;
   logic              done;
   logic [9:0][15:0]  scores;
   logic [3:0]        exp_y;

   logic              o_busy, o_valid, o_hit;
   logic [3:0]        o_class_idx;
   logic signed [15:0] o_confidence;
   logic [15:0]       o_hit_cnt, o_total_cnt;

   logic              o2_busy, o2_valid, o2_hit;
   logic [3:0]        o2_class_idx;
   logic signed [15:0] o2_confidence;
   logic [1:0]        o2_hit_cnt, o2_total_cnt;

   logic [EW-1:0]     exp_q[$];
   int                cyc_q[$];
   int                cyc = 0;
   int                n_cmp = 0;
   int                n_fail = 0;
   int                n_push = 0;
   int                n_valid = 0;
   int                m_hit = 0;
   int                m_tot = 0;
   int                last_idx = 0;
   int                last_conf = 0;
   int                last_hit = 0;
   int                vec[10];
   logic [EW-1:0]     mon_e;
   int                mon_t;

   dnn_argmax_scorer dut (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_done(done),
      .i_scores(scores), .i_exp_y(exp_y),
      .o_busy(o_busy), .o_valid(o_valid), .o_class_idx(o_class_idx),
      .o_confidence(o_confidence), .o_hit(o_hit),
      .o_hit_cnt(o_hit_cnt), .o_total_cnt(o_total_cnt)
   );

   dnn_argmax_scorer #(.CNT_WIDTH(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_done(done),
      .i_scores(scores), .i_exp_y(exp_y),
      .o_busy(o2_busy), .o_valid(o2_valid), .o_class_idx(o2_class_idx),
      .o_confidence(o2_confidence), .o_hit(o2_hit),
      .o_hit_cnt(o2_hit_cnt), .o_total_cnt(o2_total_cnt)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic int min3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"},  {31'b0, o_busy}, 0);
      check({tag, "_valid"}, {31'b0, o_valid}, 0);
      check({tag, "_idx"},   {28'b0, o_class_idx}, 0);
      check({tag, "_conf"},  {16'b0, o_confidence}, 0);
      check({tag, "_hit"},   {31'b0, o_hit}, 0);
      check({tag, "_hcnt"},  {16'b0, o_hit_cnt}, 0);
      check({tag, "_tcnt"},  {16'b0, o_total_cnt}, 0);
      check({tag, "_hcnt2"}, {30'b0, o2_hit_cnt}, 0);
      check({tag, "_tcnt2"}, {30'b0, o2_total_cnt}, 0);
   endtask

   // Driver: called at a negedge, returns at the negedge after the result edge.
   // mode 0 plain, 1 done toggle mid-scan, 2 done held 50 cycles, 3 start on reset release.
   task automatic run(input int ey, input int eidx, input int econf, input int mode);
      int  e0;
      logic h;
      for (int i = 0; i < 10; i++) scores[i] = 16'(vec[i]);
      exp_y = 4'(ey);
      done  = 1'b1;
      if (mode == 3) rst = 1'b0;
      @(posedge clk);
      #1;
      e0 = cyc;
      h  = (eidx == ey);
      m_tot++;
      if (h) m_hit++;
      exp_q.push_back({4'(eidx), 16'(econf), h, 16'(m_hit), 16'(m_tot), 2'(min3(m_hit)), 2'(min3(m_tot))});
      cyc_q.push_back(e0 + 10);
      n_push++;
      last_idx  = eidx;
      last_conf = econf;
      last_hit  = int'(h);
      @(negedge clk);
      check("busy_after_start", {31'b0, o_busy}, 1);
      for (int i = 0; i < 10; i++) scores[i] = 16'h7FFF;
      exp_y = 4'(ey ^ 5);
      if (mode != 2) done = 1'b0;
      if (mode == 1) begin
         repeat (3) @(negedge clk);
         done = 1'b1;
         @(negedge clk);
         done = 1'b0;
      end
      while (cyc < e0 + 9) @(negedge clk);
      check("busy_last_scan", {31'b0, o_busy}, 1);
      @(negedge clk);
      check("busy_after_result", {31'b0, o_busy}, 0);
      if (mode == 2) begin
         while (cyc < e0 + 50) @(negedge clk);
         done = 1'b0;
      end
   endtask

   // Start a scan and clear it when it is at scan cycle `at`; no result may appear.
   task automatic clear_mid(input int at);
      int e0;
      for (int i = 0; i < 10; i++) scores[i] = 16'(i + 1);
      done = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      @(negedge clk);
      done = 1'b0;
      while (cyc < e0 + at - 1) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_hit = 0;
      m_tot = 0;
      check("clr_busy", {31'b0, o_busy}, 0);
      check("clr_hcnt", {16'b0, o_hit_cnt}, 0);
      check("clr_tcnt", {16'b0, o_total_cnt}, 0);
      check("clr_idx_hold", {28'b0, o_class_idx}, 32'(last_idx));
      check("clr_conf_hold", {16'b0, o_confidence}, 32'(last_conf));
      check("clr_hit_hold", {31'b0, o_hit}, 32'(last_hit));
      repeat (12) @(negedge clk);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst && o_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid: valid=1, expected no result (cyc %0d)", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            mon_t = cyc_q.pop_front();
            check("latency_cycle", 32'(cyc), 32'(mon_t));
            check("class_idx", {28'b0, o_class_idx}, {28'b0, mon_e[56:53]});
            check("confidence", {16'b0, o_confidence}, {16'b0, mon_e[52:37]});
            check("hit", {31'b0, o_hit}, {31'b0, mon_e[36]});
            check("hit_cnt", {16'b0, o_hit_cnt}, {16'b0, mon_e[35:20]});
            check("total_cnt", {16'b0, o_total_cnt}, {16'b0, mon_e[19:4]});
            check("hit_cnt_sat2", {30'b0, o2_hit_cnt}, {30'b0, mon_e[3:2]});
            check("total_cnt_sat2", {30'b0, o2_total_cnt}, {30'b0, mon_e[1:0]});
            check("valid2", {31'b0, o2_valid}, 1);
            check("class_idx2", {28'b0, o2_class_idx}, {28'b0, mon_e[56:53]});
         end
      end
   end

   initial begin
      rst    = 1'b1;
      clear  = 1'b0;
      done   = 1'b0;
      scores = '0;
      exp_y  = '0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      vec = '{5, 3, 9, -2, 9, 0, 1, 1, 0, 4};
      run(3, 3, 9, 0);
      vec = '{0, -1, -2, -3, -4, -5, -6, -7, -8, -9};
      run(7, 0, 0, 0);
      run(0, 0, 0, 0);
      vec = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, 1};
      run(10, 10, 1, 0);
      vec = '{32767, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
      run(2, 1, 32767, 0);

      vec = '{1, 2, 3, 4, 40, 6, 7, 8, 9, 10};
      run(5, 5, 40, 1);
      vec = '{-1, 20, 3, 20, 5, 6, 7, 8, 9, 10};
      run(4, 2, 20, 2);
      @(negedge clk);

      clear_mid(5);
      vec = '{1, 2, 3, 4, 5, 6, 7, 8, 60, 10};
      run(9, 9, 60, 0);
      clear_mid(10);

      for (int k = 0; k < 20; k++) begin
         int w;
         w = k % 10;
         for (int i = 0; i < 10; i++) vec[i] = ((i * 7) % 13) - 6;
         vec[w] = 100 + k;
         run(((k % 2) == 0) ? (w + 1) : (((w + 1) % 10) + 1), w + 1, 100 + k, 0);
      end
      check("alt20_hit_cnt", {16'b0, o_hit_cnt}, 10);
      check("alt20_total_cnt", {16'b0, o_total_cnt}, 20);
      check("alt20_hit_cnt_sat", {30'b0, o2_hit_cnt}, 3);
      check("alt20_total_cnt_sat", {30'b0, o2_total_cnt}, 3);

      // clear on the same edge as a done rising edge: no scan
      done  = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_hit = 0;
      m_tot = 0;
      check("clr_start_busy", {31'b0, o_busy}, 0);
      check("clr_start_tcnt", {16'b0, o_total_cnt}, 0);
      done = 1'b0;
      repeat (12) @(negedge clk);

      // async reset in the middle of a scan
      vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      run(10, 10, 10, 0);
      for (int i = 0; i < 10; i++) scores[i] = 16'(i + 1);
      done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      done = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_zero_outputs("async_rst");
      m_hit = 0;
      m_tot = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);

      // done held high through reset release starts on the first clock
      rst = 1'b1;
      @(negedge clk);
      vec = '{0, 0, 7, 0, 0, 0, 0, 0, 0, 0};
      run(3, 3, 7, 3);

      repeat (15) @(negedge clk);
      check("valid_pulse_count", 32'(n_valid), 32'(n_push));
      check("pending_results", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
